// File: rtl/uart_pkg.sv
// Shared types and default timing constants for the UART transmit scheduler.
package uart_pkg;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 9600;

  // One period of the transmitter's slow baud clock, measured in clk cycles.
  localparam int BAUD_CLK_PERIOD = 2 * (CLK_FREQ / BAUD_RATE / 2 + 1);

  // newd is held a few cycles past one baud period so the slow clock always samples it.
  localparam int DEF_HOLD_CYCLES = BAUD_CLK_PERIOD + 4;

  // Generous bound covering several 10-bit frames at the default baud rate.
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } sched_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ-1.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int PW = $clog2(NREQ);

  logic [PW:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Scan from the farthest offset back toward ptr so the nearest hit is written last.
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr} + (PW + 1)'(off);
      if (cand >= (PW + 1)'(NREQ)) begin
        cand = cand - (PW + 1)'(NREQ);
      end
      if (req[cand[PW-1:0]]) begin
        found = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uarttx among NREQ byte producers: holds newd for
// HOLD_CYCLES, then waits for a fresh donetx edge (or TIMEOUT) before the next grant.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*8-1:0]       req_data,
  output logic [NREQ-1:0]         grant,
  output logic                    tx_newd,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    sent,
  output logic                    timeout_err
);

  localparam int PW    = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, TIMEOUT));

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [PW-1:0]    LAST_REQ  = PW'(NREQ - 1);

  sched_state_t state_q, state_d;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             sent_q, sent_d;
  logic             terr_q, terr_d;
  logic             done_q;

  logic                   pick_found;
  logic [PW-1:0]          pick_idx;
  logic [NREQ-1:0][7:0]   req_bytes;
  logic                   done_edge;

  assign req_bytes = req_data;
  assign done_edge = tx_done & ~done_q;

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    sent_d  = 1'b0;
    terr_d  = 1'b0;
    grant   = '0;
    tx_newd = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          data_d  = req_bytes[pick_idx];
          cnt_d   = '0;
          to_d    = 1'b0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        tx_newd = 1'b1;
        if (cnt_q == '0) begin
          grant[owner_q] = 1'b1;
        end
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A fresh edge wins over an expiry landing in the same cycle.
        if (done_edge) begin
          state_d = RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          to_d    = 1'b1;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        sent_d  = ~to_q;
        terr_d  = to_q;
        ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + PW'(1);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      data_q  <= 8'h00;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      sent_q  <= 1'b0;
      terr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      sent_q  <= sent_d;
      terr_q  <= terr_d;
      done_q  <= tx_done;
    end
  end

  assign tx_data     = data_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign sent        = sent_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed-plus-random bench for uart_tx_sched; the bench plays the transmitter's donetx
// and predicts grants with a round-robin pointer model.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int HOLD = 110;
  localparam int TMO  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              tx_newd;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic [1:0]        owner;
  logic              busy;
  logic              sent;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  uart_tx_sched #(
    .NREQ        (NREQ),
    .HOLD_CYCLES (HOLD),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .grant       (grant),
    .tx_newd     (tx_newd),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .owner       (owner),
    .busy        (busy),
    .sent        (sent),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester that wins: first asserted one at or after p, wrapping past NREQ-1.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    int res;
    logic [NREQ-1:0] t;
    res = -1;
    for (int k = 0; k < NREQ; k++) begin
      t = r >> ((p + k) % NREQ);
      if (res < 0 && t[0]) res = (p + k) % NREQ;
    end
    return res;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int i);
    return 8'(d >> (8 * i));
  endfunction

  // One complete frame: request, grant, newd hold, transmitter delay, donetx edge, sent.
  task automatic do_frame(input logic [NREQ-1:0] reqv, input logic [31:0] data,
                          input bit hold, input bit stale,
                          input logic [NREQ-1:0] short_mask, input int flen);
    int e;
    int n;
    int stray;
    logic [7:0] exp_byte;
    e        = pick(reqv, m_ptr);
    exp_byte = byte_of(data, e);
    req_data = data;
    req      = reqv;
    tx_done  = stale;
    step(1);
    check("grant", 32'(grant), 32'(1) << e);
    check("owner", 32'(owner), 32'(e));
    check("tx_data", 32'(tx_data), 32'(exp_byte));
    check("tx_newd_first", 32'(tx_newd), 32'd1);
    if (!hold) req = '0;
    n     = 1;
    stray = 0;
    for (int k = 0; k < 4 * HOLD; k++) begin
      if (k == 10) req = req | short_mask;
      if (k == 11) req = req & ~short_mask;
      step(1);
      if (!tx_newd) break;
      n++;
      if (grant != '0 || sent || timeout_err) stray++;
    end
    check("tx_newd_len", 32'(n), 32'(HOLD));
    check("load_stray", 32'(stray), 32'd0);
    stray = 0;
    if (stale) begin
      repeat (5) begin
        step(1);
        if (sent || timeout_err || !busy) stray++;
      end
      tx_done = 1'b0;
    end
    repeat (flen) begin
      step(1);
      if (sent || timeout_err || grant != '0 || !busy) stray++;
    end
    check("wait_stray", 32'(stray), 32'd0);
    tx_done = 1'b1;
    step(1);
    check("sent_u1", 32'(sent), 32'd0);
    step(1);
    check("sent_u2", 32'(sent), 32'd1);
    check("no_timeout", 32'(timeout_err), 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(exp_byte));
    m_ptr = (e + 1) % NREQ;
  endtask

  initial begin
    logic [31:0] d;
    int k;
    int sent_seen;
    int stray;
    int r;
    int e;

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    step(3);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_newd", 32'(tx_newd), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sent", 32'(sent), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    step(2);
    check("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 1 carrying A5.
    d       = $urandom;
    d[15:8] = 8'hA5;
    do_frame(4'b0010, d, 1'b0, 1'b0, 4'b0000, int'($urandom_range(20, 200)));

    // All four requesting and held: expect 0,1,2,3,0 from a fresh pointer.
    tx_done = 1'b0;
    rst     = 1'b1;
    step(1);
    rst   = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      do_frame(4'b1111, 32'h4433_2211, 1'b1, 1'b0, 4'b0000, int'($urandom_range(10, 150)));
    end
    req = '0;

    repeat (6) begin
      r = int'($urandom_range(1, 15));
      d = $urandom;
      do_frame(4'(r), d, 1'b0, 1'b0, 4'b0000, int'($urandom_range(5, 300)));
    end

    // Transmitter never answers.
    tx_done  = 1'b0;
    req_data = $urandom;
    req      = 4'b0100;
    e        = pick(4'b0100, m_ptr);
    step(1);
    check("to_grant", 32'(grant), 32'(1) << e);
    req       = '0;
    k         = 0;
    sent_seen = 0;
    while (k < 5000) begin
      step(1);
      k++;
      if (sent) sent_seen++;
      if (timeout_err) break;
    end
    check("timeout_latency", 32'(k), 32'(HOLD + TMO + 1));
    check("timeout_no_sent", 32'(sent_seen), 32'd0);
    check("timeout_idle", 32'(busy), 32'd0);
    step(1);
    check("timeout_single", 32'(timeout_err), 32'd0);
    m_ptr = (e + 1) % NREQ;
    do_frame(4'b1001, $urandom, 1'b0, 1'b0, 4'b0000, int'($urandom_range(5, 100)));

    // donetx left high from before must not complete the new frame.
    do_frame(4'b0010, $urandom, 1'b0, 1'b1, 4'b0000, int'($urandom_range(5, 100)));

    // Reset 50 cycles into LOAD.
    tx_done  = 1'b0;
    d        = $urandom;
    d[7:0]   = 8'hC3;
    req_data = d;
    req      = 4'b0001;
    step(1);
    check("abort_grant", 32'(grant), 32'd1);
    req = '0;
    step(49);
    check("abort_in_load", 32'(tx_newd), 32'd1);
    rst = 1'b1;
    step(1);
    check("abort_grant0", 32'(grant), 32'd0);
    check("abort_tx_newd", 32'(tx_newd), 32'd0);
    check("abort_tx_data", 32'(tx_data), 32'd0);
    check("abort_owner", 32'(owner), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sent", 32'(sent), 32'd0);
    check("abort_timeout", 32'(timeout_err), 32'd0);
    rst   = 1'b0;
    m_ptr = 0;
    stray = 0;
    repeat (5) begin
      step(1);
      if (sent || timeout_err || busy) stray++;
    end
    check("abort_quiet", 32'(stray), 32'd0);
    do_frame(4'b1010, $urandom, 1'b0, 1'b0, 4'b0000, int'($urandom_range(5, 100)));

    // Requester 3 granted normally while requester 0 flashes a one-cycle request.
    do_frame(4'b1000, $urandom, 1'b0, 1'b0, 4'b0001, int'($urandom_range(5, 100)));
    tx_done = 1'b0;
    stray   = 0;
    repeat (20) begin
      step(1);
      if (grant != '0 || busy) stray++;
    end
    check("short_req_ignored", 32'(stray), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
